// File: rtl/scoreboard_nway.sv
// In-order N-way issue scoreboard: register-status table, FU allocation and trap drain.
// Grants up to ISSUE_W program-ordered slots per cycle onto the lowest free eligible FU.
module scoreboard_nway #(
    parameter int ISSUE_W = 2,
    parameter int NUM_FU  = 3,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ISSUE_W-1:0]          slot_valid,
    input  logic [ISSUE_W*REG_AW-1:0]   slot_rs1,
    input  logic [ISSUE_W*REG_AW-1:0]   slot_rs2,
    input  logic [ISSUE_W-1:0]          slot_rs1_en,
    input  logic [ISSUE_W-1:0]          slot_rs2_en,
    input  logic [ISSUE_W*REG_AW-1:0]   slot_rd,
    input  logic [ISSUE_W-1:0]          slot_rd_en,
    input  logic [ISSUE_W*NUM_FU-1:0]   slot_fu_ok,
    input  logic [NUM_FU-1:0]           wb_valid,
    input  logic                        flush,
    input  logic                        trap_req,
    output logic [ISSUE_W-1:0]          issue_fire,
    output logic [ISSUE_W*NUM_FU-1:0]   issue_fu,
    output logic [NUM_FU-1:0]           fu_busy,
    output logic                        drained,
    output logic [CNT_W-1:0]            stall_cycles
);

    localparam int NREG = 2**REG_AW;
    localparam int FW   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [NREG-1:0]   pend;
    logic [FW-1:0]     prod [NREG];
    logic [NUM_FU-1:0] busy;
    logic [REG_AW-1:0] dst [NUM_FU];
    logic [NUM_FU-1:0] dst_en;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              grant_en;
    logic              quiet;

    logic [REG_AW-1:0] rs1_a, rs2_a, rd_a, rd_old;
    logic              hazard, chain;
    logic [NUM_FU-1:0] used, avail, pick;

    // Reset gates grants combinationally so the outputs are quiet while rst is low.
    assign grant_en = rst && (state == RUN) && !trap_req && !flush;
    assign quiet    = ((busy & ~wb_valid) == '0);
    assign fu_busy  = busy;
    assign drained  = (state == DONE);

    always_comb begin
        used       = '0;
        chain      = grant_en;
        issue_fire = '0;
        issue_fu   = '0;
        rs1_a      = '0;
        rs2_a      = '0;
        rd_a       = '0;
        rd_old     = '0;
        hazard     = 1'b0;
        avail      = '0;
        pick       = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            rs1_a  = slot_rs1[i*REG_AW +: REG_AW];
            rs2_a  = slot_rs2[i*REG_AW +: REG_AW];
            rd_a   = slot_rd[i*REG_AW +: REG_AW];
            hazard = (slot_rs1_en[i] && rs1_a != '0 && pend[rs1_a])
                  || (slot_rs2_en[i] && rs2_a != '0 && pend[rs2_a])
                  || (slot_rd_en[i]  && rd_a  != '0 && pend[rd_a]);
            // Older slots in the group are known to fire, so their rd is already in flight.
            for (int j = 0; j < i; j++) begin
                rd_old = slot_rd[j*REG_AW +: REG_AW];
                if (slot_rd_en[j] && rd_old != '0) begin
                    if ((slot_rs1_en[i] && rs1_a == rd_old) ||
                        (slot_rs2_en[i] && rs2_a == rd_old) ||
                        (slot_rd_en[i]  && rd_a  == rd_old))
                        hazard = 1'b1;
                end
            end
            avail = slot_fu_ok[i*NUM_FU +: NUM_FU] & ~busy & ~used;
            pick  = avail & (~avail + NUM_FU'(1));
            chain = chain && slot_valid[i] && !hazard && (avail != '0);
            if (chain) begin
                issue_fire[i]                 = 1'b1;
                issue_fu[i*NUM_FU +: NUM_FU]  = pick;
                used                          = used | pick;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (trap_req) next_state = quiet ? DONE : DRAIN;
            DRAIN:   if (quiet) next_state = DONE;
            DONE:    next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Writeback effects first, then issue effects, so a same-edge issue wins on pend/prod.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend   <= '0;
            busy   <= '0;
            dst_en <= '0;
            for (int r = 0; r < NREG; r++) prod[r] <= '0;
            for (int f = 0; f < NUM_FU; f++) dst[f] <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (wb_valid[f] && busy[f]) begin
                    busy[f] <= 1'b0;
                    if (dst_en[f] && prod[dst[f]] == FW'(f))
                        pend[dst[f]] <= 1'b0;
                end
            end
            for (int i = 0; i < ISSUE_W; i++) begin
                for (int f = 0; f < NUM_FU; f++) begin
                    if (issue_fire[i] && issue_fu[i*NUM_FU + f]) begin
                        busy[f]   <= 1'b1;
                        dst[f]    <= slot_rd[i*REG_AW +: REG_AW];
                        dst_en[f] <= slot_rd_en[i] && (slot_rd[i*REG_AW +: REG_AW] != '0);
                        if (slot_rd_en[i] && slot_rd[i*REG_AW +: REG_AW] != '0) begin
                            pend[slot_rd[i*REG_AW +: REG_AW]] <= 1'b1;
                            prod[slot_rd[i*REG_AW +: REG_AW]] <= FW'(f);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (state == RUN && !flush && slot_valid[0] && !issue_fire[0]
                     && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
